// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run / single-cycle / single-instruction sequencer for the
// multi-cycle CPU. Produces the CPU clock enable and the cycle and
// retired-instruction counters shown on the display.
module cpu_step_ctrl #(
  parameter int unsigned       PC_W   = 32,
  parameter int unsigned       CNT_W  = 16,
  parameter int unsigned       BEAT_W = 5,
  parameter logic [BEAT_W-1:0] FETCH  = BEAT_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              go,
  input  logic              stop,
  input  logic              clr_cnt,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc,
  input  logic [BEAT_W-1:0] beat,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              running,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_STEP_CYC = 2'b01,
    ST_STEP_INS = 2'b10,
    ST_RUN      = 2'b11
  } state_e;

  state_e           state_q;
  logic             running_q;
  logic             bp_hit_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;
  logic             en_q;     // cpu_en of the previous cycle
  logic             fetch_q;  // beat was FETCH at the last enabled edge

  logic is_fetch;
  logic retire;
  logic bp_halt;
  logic halt_now;

  // Retire detection, halt conditions and the CPU clock enable.
  // A non-one-hot beat can never equal the one-hot FETCH value, so it is
  // naturally treated as non-fetch.
  always_comb begin
    is_fetch = (beat == FETCH);
    retire   = en_q & is_fetch & ~fetch_q;
    bp_halt  = (state_q == ST_RUN) & retire & bp_en & (pc == bp_addr);
    halt_now = stop | ((state_q == ST_STEP_INS) & retire) | bp_halt;
    cpu_en   = (state_q != ST_IDLE) & ~halt_now & ~rst;
  end

  // Sequencer state, sticky breakpoint flag, retire tracking and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      bp_hit_q  <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
      en_q      <= 1'b0;
      fetch_q   <= 1'b0;
    end else begin
      en_q <= cpu_en;
      if (cpu_en) begin
        fetch_q <= is_fetch;
      end

      if (clr_cnt) begin
        cycle_q <= '0;
        instr_q <= '0;
      end else begin
        if (cpu_en) begin
          cycle_q <= cycle_q + CNT_W'(1);
        end
        if (retire) begin
          instr_q <= instr_q + CNT_W'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          // stop beats a simultaneous go; mode 00 keeps the sequencer idle
          if (go && !stop) begin
            case (mode)
              2'b01: begin
                state_q  <= ST_STEP_CYC;
                bp_hit_q <= 1'b0;
              end
              2'b10: begin
                state_q  <= ST_STEP_INS;
                bp_hit_q <= 1'b0;
              end
              2'b11: begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
                bp_hit_q  <= 1'b0;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_STEP_CYC: begin
          state_q <= ST_IDLE;
        end
        ST_STEP_INS: begin
          if (halt_now) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (halt_now) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
          if (bp_halt) begin
            bp_hit_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign state     = state_q;
  assign running   = running_q;
  assign bp_hit    = bp_hit_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: directed vector table, hand-written
// breakpoint / resume / reset / counter-wrap sequences, and a randomized
// phase checked against a rule-level reference model.
module tb_cpu_step_ctrl;

  localparam logic [4:0] B_F = 5'b00001;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_W = 5'b01000;

  logic        clk = 1'b0;
  logic        rst, go, stop, clr_cnt, bp_en;
  logic [1:0]  mode;
  logic [31:0] bp_addr, pc;
  logic [4:0]  beat;
  logic        cpu_en, running, bp_hit;
  logic [1:0]  state;
  logic [15:0] cycle_cnt, instr_cnt;

  cpu_step_ctrl dut (
    .clk(clk), .rst(rst), .mode(mode), .go(go), .stop(stop),
    .clr_cnt(clr_cnt), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .beat(beat), .cpu_en(cpu_en), .state(state), .running(running),
    .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  bit cmp_on = 1'b0;
  bit cpu_on = 1'b1;

  // reference model: sequencer activity, counters as plain integers
  int          m_state;
  bit          m_bp, m_en_prev, m_fetch_prev;
  int unsigned m_cyc, m_ins;
  bit          e_en, e_fetch, e_retire, e_halt, e_bphalt;

  // values sampled mid-cycle by the last call to cycle()
  bit          smp_en, smp_bp;
  logic [1:0]  smp_state;
  logic [15:0] smp_cyc, smp_ins;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Expected combinational behaviour for the current inputs.
  function automatic void model_eval();
    e_fetch  = ($countones(beat) == 1) && beat[0];
    e_retire = m_en_prev && e_fetch && !m_fetch_prev;
    e_bphalt = (m_state == 3) && e_retire && bp_en && (pc == bp_addr);
    e_halt   = stop || ((m_state == 2) && e_retire) || e_bphalt;
    e_en     = !rst && (m_state != 0) && !e_halt;
  endfunction

  // Model update for one clock edge, using the inputs held across it.
  function automatic void model_commit();
    if (rst) begin
      m_state = 0; m_bp = 0; m_cyc = 0; m_ins = 0;
      m_en_prev = 0; m_fetch_prev = 0;
    end else begin
      if (e_en) m_fetch_prev = e_fetch;
      m_en_prev = e_en;
      if (clr_cnt) begin
        m_cyc = 0;
        m_ins = 0;
      end else begin
        m_cyc = (m_cyc + (e_en ? 1 : 0)) % 65536;
        m_ins = (m_ins + (e_retire ? 1 : 0)) % 65536;
      end
      if (m_state == 0) begin
        if (go && !stop && mode != 2'd0) begin
          m_state = int'(mode);
          m_bp    = 0;
        end
      end else if (m_state == 1) begin
        m_state = 0;
      end else begin
        if (e_halt) m_state = 0;
        if (e_bphalt) m_bp = 1;
      end
    end
  endfunction

  // Simple CPU: beats F,D,E,W; PC advances by 4 as W hands over to F.
  function automatic void cpu_advance();
    if (cpu_on && e_en) begin
      if (beat == B_W) begin
        pc   = pc + 32'd4;
        beat = B_F;
      end else begin
        beat = {beat[3:0], 1'b0};
      end
    end
  endfunction

  // One clock cycle: drive, sample and compare mid-cycle, clock, update model.
  task automatic cycle(input bit r, input logic [1:0] md, input bit g,
                       input bit s, input bit c);
    rst = r; mode = md; go = g; stop = s; clr_cnt = c;
    #1;
    model_eval();
    smp_en = cpu_en; smp_bp = bp_hit; smp_state = state;
    smp_cyc = cycle_cnt; smp_ins = instr_cnt;
    if (cmp_on) begin
      chk("mdl_cpu_en",  cyc_no, 32'(cpu_en),    32'(e_en));
      chk("mdl_state",   cyc_no, 32'(state),     32'(m_state));
      chk("mdl_running", cyc_no, 32'(running),   32'(m_state == 3));
      chk("mdl_bp_hit",  cyc_no, 32'(bp_hit),    32'(m_bp));
      chk("mdl_cycle",   cyc_no, 32'(cycle_cnt), 32'(m_cyc));
      chk("mdl_instr",   cyc_no, 32'(instr_cnt), 32'(m_ins));
    end
    @(posedge clk);
    #1;
    model_commit();
    cpu_advance();
    cyc_no++;
  endtask

  typedef struct {
    bit         r;
    logic [1:0] md;
    bit         g, s, c;
    bit         en;
    logic [1:0] st;
    bit         bp;
    int         cyc, ins;
  } vec_t;

  vec_t tbl[20];
  int   n_en;
  int   sel;

  initial begin
    // r  md  g  s  c   | en st  bp cyc ins   (expected mid-cycle)
    tbl[0]  = '{0, 2'd0, 0, 0, 0,  0, 2'd0, 0, 0, 0};
    tbl[1]  = '{0, 2'd1, 1, 1, 0,  0, 2'd0, 0, 0, 0}; // go+stop: stop wins
    tbl[2]  = '{0, 2'd1, 0, 0, 0,  0, 2'd0, 0, 0, 0};
    tbl[3]  = '{0, 2'd0, 1, 0, 0,  0, 2'd0, 0, 0, 0}; // go in halt mode
    tbl[4]  = '{0, 2'd0, 0, 0, 0,  0, 2'd0, 0, 0, 0};
    tbl[5]  = '{0, 2'd2, 1, 0, 0,  0, 2'd0, 0, 0, 0}; // instruction step
    tbl[6]  = '{0, 2'd2, 0, 0, 0,  1, 2'd2, 0, 0, 0}; // F
    tbl[7]  = '{0, 2'd3, 1, 0, 0,  1, 2'd2, 0, 1, 0}; // D, go ignored
    tbl[8]  = '{0, 2'd0, 0, 0, 0,  1, 2'd2, 0, 2, 0}; // E
    tbl[9]  = '{0, 2'd0, 0, 0, 0,  1, 2'd2, 0, 3, 0}; // W
    tbl[10] = '{0, 2'd0, 0, 0, 0,  0, 2'd2, 0, 4, 0}; // F again: retire+halt
    tbl[11] = '{0, 2'd0, 0, 0, 0,  0, 2'd0, 0, 4, 1};
    tbl[12] = '{0, 2'd1, 1, 0, 0,  0, 2'd0, 0, 4, 1}; // cycle step
    tbl[13] = '{0, 2'd1, 0, 0, 0,  1, 2'd1, 0, 4, 1};
    tbl[14] = '{0, 2'd1, 0, 0, 0,  0, 2'd0, 0, 5, 1};
    tbl[15] = '{0, 2'd0, 0, 0, 1,  0, 2'd0, 0, 5, 1}; // clear counters
    tbl[16] = '{0, 2'd0, 0, 0, 0,  0, 2'd0, 0, 0, 0};
    tbl[17] = '{0, 2'd1, 1, 0, 0,  0, 2'd0, 0, 0, 0}; // cycle step ...
    tbl[18] = '{0, 2'd0, 0, 1, 0,  0, 2'd1, 0, 0, 0}; // ... killed by stop
    tbl[19] = '{0, 2'd0, 0, 0, 0,  0, 2'd0, 0, 0, 0};

    rst = 1'b1; go = 1'b0; stop = 1'b0; clr_cnt = 1'b0; mode = 2'd0;
    bp_en = 1'b0; bp_addr = 32'h0000_000C; pc = 32'h0; beat = B_F;
    m_state = 0; m_bp = 0; m_cyc = 0; m_ins = 0; m_en_prev = 0; m_fetch_prev = 0;
    @(posedge clk);
    #1;
    cycle(1, 2'd0, 0, 0, 0);
    cycle(1, 2'd0, 0, 0, 0);
    cmp_on = 1'b1;

    // directed vector table
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].r, tbl[i].md, tbl[i].g, tbl[i].s, tbl[i].c);
      chk("tbl_cpu_en", i, 32'(smp_en),    32'(tbl[i].en));
      chk("tbl_state",  i, 32'(smp_state), 32'(tbl[i].st));
      chk("tbl_bp_hit", i, 32'(smp_bp),    32'(tbl[i].bp));
      chk("tbl_cycle",  i, 32'(smp_cyc),   32'(tbl[i].cyc));
      chk("tbl_instr",  i, 32'(smp_ins),   32'(tbl[i].ins));
    end

    // breakpoint run from pc=0: halts as pc reaches 0xC
    beat = B_F; pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h0000_000C;
    cycle(0, 2'd3, 1, 0, 0);
    n_en = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 2'd3, 0, 0, 0);
      if (smp_en) n_en++;
      if (state == 2'd0) break;
    end
    chk("bp_en_cycles", 0, 32'(n_en),      32'd12);
    chk("bp_state",     0, 32'(state),     32'd0);
    chk("bp_running",   0, 32'(running),   32'd0);
    chk("bp_hit",       0, 32'(bp_hit),    32'd1);
    chk("bp_pc",        0, pc,             32'h0000_000C);
    chk("bp_instr",     0, 32'(instr_cnt), 32'd3);
    chk("bp_cycle",     0, 32'(cycle_cnt), 32'd12);

    // resume at the breakpoint pc: no immediate re-hit, bp_hit clears
    cycle(0, 2'd3, 1, 0, 0);
    chk("res_bp_before", 0, 32'(smp_bp), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 2'd0, 0, 0, 0);
      chk("res_cpu_en", i, 32'(smp_en),    32'd1);
      chk("res_state",  i, 32'(smp_state), 32'd3);
      chk("res_bp_hit", i, 32'(smp_bp),    32'd0);
    end
    chk("res_pc", 0, pc, 32'h0000_0010);
    cycle(0, 2'd0, 0, 1, 0);
    chk("res_stop_en", 0, 32'(smp_en), 32'd0);
    chk("res_stop_st", 0, 32'(state),  32'd0);
    chk("res_instr",   0, 32'(instr_cnt), 32'd4);

    // reset held for two cycles in the middle of a run
    cycle(0, 2'd3, 1, 0, 0);
    cycle(0, 2'd3, 0, 0, 0);
    cycle(0, 2'd3, 0, 0, 0);
    cycle(1, 2'd3, 0, 0, 0);
    chk("rst_en0", 0, 32'(smp_en), 32'd0);
    cycle(1, 2'd3, 0, 0, 0);
    chk("rst_en1", 0, 32'(smp_en), 32'd0);
    chk("rst_state", 0, 32'(state),     32'd0);
    chk("rst_bp",    0, 32'(bp_hit),    32'd0);
    chk("rst_cycle", 0, 32'(cycle_cnt), 32'd0);
    chk("rst_instr", 0, 32'(instr_cnt), 32'd0);

    // cycle counter wrap, then clr_cnt winning over an enabled cycle
    bp_en = 1'b0;
    cycle(0, 2'd3, 1, 0, 0);
    for (int i = 0; i < 70000 && cycle_cnt != 16'hFFFF; i++) begin
      cycle(0, 2'd3, 0, 0, 0);
    end
    chk("wrap_pre", 0, 32'(cycle_cnt), 32'h0000_FFFF);
    cycle(0, 2'd3, 0, 0, 0);
    chk("wrap_en",  0, 32'(smp_en),    32'd1);
    chk("wrap_cnt", 0, 32'(cycle_cnt), 32'd0);
    cycle(0, 2'd3, 0, 0, 0);
    cycle(0, 2'd3, 0, 0, 1);
    chk("clr_en",    0, 32'(smp_en),    32'd1);
    chk("clr_cycle", 0, 32'(cycle_cnt), 32'd0);
    chk("clr_instr", 0, 32'(instr_cnt), 32'd0);
    cycle(0, 2'd0, 0, 1, 0);

    // randomized inputs; beat and pc driven directly
    cpu_on = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0, 1:    beat = B_F;
        2:       beat = B_D;
        3:       beat = 5'b00100;
        4:       beat = B_W;
        5:       beat = 5'b10000;
        default: beat = 5'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       pc = 32'h0000_000C;
        1:       pc = 32'h0000_0010;
        default: pc = 32'($urandom_range(0, 15));
      endcase
      bp_en = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
